// File: rtl/fpu_normalizer_if.sv
// Handshake bundle between the add/sub stage, the normalizer and its consumer.
// Upstream drives in_*/out_ready (master); the normalizer drives in_ready/out_* (slave).
interface fpu_normalizer_if #(
  parameter int WIDTH = 64,
  parameter int EXP_W = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   in_mant;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic             out_sign;
  logic             out_zero;
  logic             out_ovf;
  logic             out_unf;
  logic             out_sticky;

  modport master (
    output in_valid, in_mant, in_sign, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_sign,
           out_zero, out_ovf, out_unf, out_sticky
  );

  modport slave (
    input  in_valid, in_mant, in_sign, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_sign,
           out_zero, out_ovf, out_unf, out_sticky
  );
endinterface

// File: rtl/fpu_normalizer.sv
// Normalizes an add/sub magnitude to a leading one at bit WIDTH-1, one bit per cycle; FPU_NORM_STICKY_EN enables out_sticky.
// Latency: out_valid 1+k edges after the accept edge (2+k counting it), k = left shifts.
// Backpressure: one transaction in flight; in_ready low until the result handshakes out.
module fpu_normalizer #(
  parameter int WIDTH = 64,
  parameter int EXP_W = 11
) (
  input logic              clk,
  input logic              rst,
  fpu_normalizer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] mant;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             zero;
    logic             ovf;
    logic             unf;
  } res_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   mant_q, mant_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [EXP_W-1:0] exp_inc;
  logic             sign_q;
  res_t             res_q, res_d;
  logic             res_load;
  logic             accept;

  assign bus.in_ready = (state_q == IDLE) & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;
  assign exp_inc      = exp_q + EXP_W'(1);

  always_comb begin
    state_d       = state_q;
    mant_d        = mant_q;
    exp_d         = exp_q;
    res_load      = 1'b0;
    res_d.mant    = mant_q[WIDTH-1:0];
    res_d.exp     = exp_q;
    res_d.sign    = sign_q;
    res_d.zero    = 1'b0;
    res_d.ovf     = 1'b0;
    res_d.unf     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          mant_d  = bus.in_mant;
          exp_d   = bus.in_exp;
        end
      end
      SHIFT: begin
        if (mant_q == '0) begin
          state_d    = DONE;
          res_load   = 1'b1;
          res_d.zero = 1'b1;
          res_d.sign = 1'b0;
          res_d.exp  = '0;
          res_d.mant = '0;
        end else if (mant_q[WIDTH]) begin
          // Carry-out: one right shift always suffices, all-ones exponent means overflow.
          state_d    = DONE;
          res_load   = 1'b1;
          res_d.mant = mant_q[WIDTH:1];
          res_d.exp  = exp_inc;
          res_d.ovf  = &exp_inc;
        end else if (mant_q[WIDTH-1]) begin
          state_d  = DONE;
          res_load = 1'b1;
        end else if (exp_q == '0) begin
          state_d   = DONE;
          res_load  = 1'b1;
          res_d.unf = 1'b1;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      if (accept)   sign_q <= bus.in_sign;
      if (res_load) res_q  <= res_d;
    end
  end

`ifdef FPU_NORM_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (accept) begin
      sticky_q <= 1'b0;
    end else if (state_q == SHIFT && mant_q[WIDTH]) begin
      sticky_q <= mant_q[0];
    end
  end

  assign bus.out_sticky = sticky_q;
`else
  assign bus.out_sticky = 1'b0;
`endif

  assign bus.out_valid = (state_q == DONE);
  assign bus.out_mant  = res_q.mant;
  assign bus.out_exp   = res_q.exp;
  assign bus.out_sign  = res_q.sign;
  assign bus.out_zero  = res_q.zero;
  assign bus.out_ovf   = res_q.ovf;
  assign bus.out_unf   = res_q.unf;

endmodule

// File: doc/fpu_normalizer.md
FPU_NORMALIZER -- requirements
Module: fpu_normalizer

Interface
REQ-001 Parameter WIDTH, default 64, mantissa width; input magnitude is WIDTH+1 bits.
REQ-002 Parameter EXP_W, default 11, biased exponent width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream add/sub result valid.
REQ-006 in_ready  output  1  block can accept; high only in IDLE with rst low.
REQ-007 in_mant  input  WIDTH+1  unsigned magnitude from add/sub stage; bit WIDTH is carry-out.
REQ-008 in_sign  input  1  result sign from add/sub stage.
REQ-009 in_exp  input  EXP_W  common biased exponent of aligned operands.
REQ-010 out_valid  output  1  normalized result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_mant  output  WIDTH  normalized mantissa; bit WIDTH-1 is the leading one.
REQ-013 out_exp  output  EXP_W  adjusted biased exponent.
REQ-014 out_sign, out_zero, out_ovf, out_unf, out_sticky  output  1 each  sign, zero result, exponent overflow, exponent underflow, bit lost on right shift.

Function
REQ-015 States: IDLE, SHIFT, DONE; one transaction in flight at a time.
REQ-016 Accept on rising edge with in_valid & in_ready: capture in_mant, in_sign, in_exp; IDLE->SHIFT.
REQ-017 SHIFT, evaluated once per cycle, in priority order:
  - mant==0 -> DONE; out_zero=1, out_sign=0, out_exp=0, out_mant=0.
  - mant[WIDTH]==1 -> shift right 1, exp+1, sticky=mant[0]; DONE; out_ovf=1 if new exp equals 2^EXP_W-1.
  - mant[WIDTH-1]==1 -> DONE, no change.
  - exp==0 -> DONE; out_unf=1, mantissa left unnormalized.
  - else shift left 1, exp-1, remain in SHIFT.
REQ-018 Latency: out_valid rises 2 edges after the accept edge when no left shift is needed; 2+k edges with k left shifts; k <= WIDTH-1.
REQ-019 DONE: out_valid=1; all out_* held stable until out_valid & out_ready, then DONE->IDLE on that edge.
REQ-020 in_ready=0 in SHIFT and DONE; no accept on the edge that completes an output handshake.
REQ-021 out_* other than out_valid are don't-care (held at last value) outside DONE.
REQ-022 Exponent arithmetic is unsigned EXP_W-bit; increment never wraps because of the REQ-017 check; decrement never goes below 0.

Reset
REQ-023 rst asserted at any time, including mid-SHIFT or DONE: state->IDLE immediately; all out_* and internal registers->0; in_ready=0 while rst high.
REQ-024 The first accept is possible on the first rising edge after rst deasserts; an in-flight transaction is discarded with no output.

Configuration
REQ-025 Macro FPU_NORM_STICKY_EN defined: out_sticky carries the bit lost by the REQ-017 right shift, cleared on each accept.
REQ-026 Macro FPU_NORM_STICKY_EN undefined: out_sticky tied to 0 and no sticky register is built; all other behaviour is identical.

Verification (WIDTH=8, EXP_W=5)
REQ-027 mant=9'h080, exp=10, sign=1 -> out_mant=8'h80, out_exp=10, out_sign=1, out_valid 2 edges after accept.
REQ-028 mant=9'h001, exp=20 -> 7 left shifts; out_mant=8'h80, out_exp=13, out_valid 9 edges after accept.
REQ-029 mant=9'h181, exp=10 -> out_mant=8'hC0, out_exp=11, out_sticky=1 (0 without macro); exp=30 gives out_exp=31, out_ovf=1.
REQ-030 mant=9'h000, sign=1 -> out_zero=1, out_sign=0, out_exp=0; mant=9'h004, exp=3 -> out_mant=8'h20, out_exp=0, out_unf=1.
REQ-031 out_ready held low 5 cycles in DONE -> outputs stable and in_ready=0 throughout; returns to IDLE on the edge with out_ready=1.
REQ-032 rst pulsed during SHIFT of mant=9'h001 -> out_valid never asserts, outputs=0; the next transaction completes normally.
